// File: rtl/adder_bist_checker.sv
// Built-in self-test engine for a WIDTH-bit adder: walks every {a,b} pair,
// samples {cout,s} after a settle delay and records mismatches against a+b.
module adder_bist_checker #(
   parameter int WIDTH         = 2,
   parameter int SETTLE_CYCLES = 1,
   parameter bit STOP_ON_FAIL  = 1'b0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   output logic [WIDTH-1:0]   a_out,
   output logic [WIDTH-1:0]   b_out,
   input  logic [WIDTH-1:0]   s_in,
   input  logic               cout_in,
   output logic               busy,
   output logic               done,
   output logic               pass,
   output logic [2*WIDTH:0]   err_count,
   output logic [2*WIDTH-1:0] fail_vec,
   output logic [WIDTH:0]     fail_res
);

   localparam int IW = 2 * WIDTH;
   localparam int EW = 2 * WIDTH + 1;
   localparam int CW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE,
      SETTLE,
      CHECK,
      DONE
   } state_t;

   state_t          state;
   logic [IW-1:0]   idx;
   logic [CW-1:0]   settle_cnt;
   logic [WIDTH:0]  expected;
   logic [WIDTH:0]  observed;
   logic            mismatch;
   logic            last_vec;

   // Operands come straight off the index flops, so they are glitch-free
   // registered outputs and hold their last value once the run ends.
   assign a_out    = idx[IW-1:WIDTH];
   assign b_out    = idx[WIDTH-1:0];
   assign expected = {1'b0, a_out} + {1'b0, b_out};
   assign observed = {cout_in, s_in};
   assign mismatch = (observed != expected);
   assign last_vec = &idx;

   // NOTE: every register here is updated with <= so all reads in this block
   // see the pre-edge value; blocking = would make order of statements matter.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         idx        <= '0;
         settle_cnt <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_vec   <= '0;
         fail_res   <= '0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= SETTLE;
                  idx        <= '0;
                  settle_cnt <= '0;
                  busy       <= 1'b1;
                  done       <= 1'b0;
                  pass       <= 1'b0;
                  err_count  <= '0;
                  fail_vec   <= '0;
                  fail_res   <= '0;
               end
            end

            SETTLE: begin
               if (settle_cnt == CW'(SETTLE_CYCLES - 1)) begin
                  state <= CHECK;
               end else begin
                  settle_cnt <= settle_cnt + CW'(1);
               end
            end

            CHECK: begin
               if (mismatch) begin
                  err_count <= err_count + EW'(1);
                  if (err_count == '0) begin
                     fail_vec <= idx;
                     fail_res <= observed;
                  end
               end
               if (last_vec || (STOP_ON_FAIL && mismatch)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_count == '0) && !mismatch;
               end else begin
                  idx        <= idx + IW'(1);
                  settle_cnt <= '0;
                  state      <= SETTLE;
               end
            end

            // NOTE: an explicit default recovers from any illegal encoding.
            default: state <= IDLE;
         endcase
      end
   end

endmodule
